fl_frame_gen: RTL and testbench

FL_FRAME_GEN -- requirements
Module: fl_frame_gen

---
 rtl/fl_frame_gen_if.sv | 25 ++
 rtl/fl_frame_gen.sv | 165 ++++++++++++++++
 tb/tb_fl_frame_gen.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fl_frame_gen_if.sv
// rtl/fl_frame_gen_if.sv - FrameLink transmit interface for fl_frame_gen
interface fl_frame_gen_if #(
  parameter int DATA_WIDTH = 32
) ();
  localparam int REM_W = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1;

  logic [DATA_WIDTH-1:0] TX_DATA;
  logic [REM_W-1:0]      TX_REM;
  logic                  TX_SOF_N;
  logic                  TX_EOF_N;
  logic                  TX_SOP_N;
  logic                  TX_EOP_N;
  logic                  TX_SRC_RDY_N;
  logic                  TX_DST_RDY_N;

  modport master (
    output TX_DATA, TX_REM, TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N, TX_SRC_RDY_N,
    input  TX_DST_RDY_N
  );

  modport slave (
    input  TX_DATA, TX_REM, TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N, TX_SRC_RDY_N,
    output TX_DST_RDY_N
  );
endinterface

// File: rtl/fl_frame_gen.sv
// rtl/fl_frame_gen.sv - FrameLink test frame generator (optional header part + payload part)
module fl_frame_gen #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  input  logic                STOP,
  input  logic [15:0]         FRAME_COUNT,
  input  logic [15:0]         HDR_LEN,
  input  logic [15:0]         PAY_LEN,
  input  logic [7:0]          SEED,
  fl_frame_gen_if.master      tx,
  output logic                BUSY,
  output logic                ERR,
  output logic [15:0]         FRAMES_SENT
);
  localparam int BPW   = DATA_WIDTH / 8;
  localparam int LOG   = (BPW > 1) ? $clog2(BPW) : 0;
  localparam int REM_W = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY} state_t;

  state_t      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [15:0] frames_q, frames_d;
  logic [15:0] fc_q, fc_d;
  logic [15:0] hdr_q, hdr_d;
  logic [15:0] pay_q, pay_d;
  logic [7:0]  seed_q, seed_d;
  logic        stop_q, stop_d;
  logic        err_q, err_d;

  logic [15:0] part_len;
  logic [16:0] n_words;
  logic        last_word;
  logic        xfer;
  logic [15:0] rem_mask;
  logic [DATA_WIDTH-1:0] word_data;
  logic [31:0] byte_idx;

  assign part_len  = (state_q == S_HDR) ? hdr_q : pay_q;
  assign n_words   = ({1'b0, part_len} + 17'(BPW - 1)) >> LOG;
  assign last_word = ({1'b0, word_q} == (n_words - 17'd1));
  assign xfer      = !tx.TX_DST_RDY_N;
  assign rem_mask  = (part_len - 16'd1) & 16'(BPW - 1);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      word_q   <= '0;
      frames_q <= '0;
      fc_q     <= '0;
      hdr_q    <= '0;
      pay_q    <= '0;
      seed_q   <= '0;
      stop_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      frames_q <= frames_d;
      fc_q     <= fc_d;
      hdr_q    <= hdr_d;
      pay_q    <= pay_d;
      seed_q   <= seed_d;
      stop_q   <= stop_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    frames_d = frames_q;
    fc_d     = fc_q;
    hdr_d    = hdr_q;
    pay_d    = pay_q;
    seed_d   = seed_q;
    stop_d   = stop_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        if (START) begin
          if (PAY_LEN != 16'd0) begin
            fc_d     = FRAME_COUNT;
            hdr_d    = HDR_LEN;
            pay_d    = PAY_LEN;
            seed_d   = SEED;
            frames_d = '0;
            word_d   = '0;
            state_d  = (HDR_LEN != 16'd0) ? S_HDR : S_PAY;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_HDR: begin
        if (STOP) stop_d = 1'b1;
        if (xfer) begin
          if (last_word) begin
            word_d  = '0;
            state_d = S_PAY;
          end else begin
            word_d = word_q + 16'd1;
          end
        end
      end
      S_PAY: begin
        if (STOP) stop_d = 1'b1;
        if (xfer) begin
          if (last_word) begin
            frames_d = frames_q + 16'd1;
            word_d   = '0;
            // A STOP coinciding with the EOF transfer still ends the run here
            if (((fc_q != 16'd0) && (frames_d == fc_q)) || stop_q || STOP) begin
              state_d = S_IDLE;
              stop_d  = 1'b0;
            end else begin
              state_d = (hdr_q != 16'd0) ? S_HDR : S_PAY;
            end
          end else begin
            word_d = word_q + 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    word_data = '0;
    byte_idx  = '0;
    for (int j = 0; j < BPW; j++) begin
      byte_idx = (32'(word_q) << LOG) + 32'(j);
      if (byte_idx < 32'(part_len))
        word_data[j*8 +: 8] = seed_q + byte_idx[7:0];
    end
  end

  always_comb begin
    tx.TX_DATA      = '0;
    tx.TX_REM       = '0;
    tx.TX_SOF_N     = 1'b1;
    tx.TX_EOF_N     = 1'b1;
    tx.TX_SOP_N     = 1'b1;
    tx.TX_EOP_N     = 1'b1;
    tx.TX_SRC_RDY_N = 1'b1;
    BUSY            = 1'b0;
    if (state_q != S_IDLE) begin
      tx.TX_SRC_RDY_N = 1'b0;
      BUSY            = 1'b1;
      tx.TX_DATA      = word_data;
      tx.TX_SOP_N     = (word_q != 16'd0);
      tx.TX_EOP_N     = !last_word;
      tx.TX_SOF_N     = !((word_q == 16'd0) && ((state_q == S_HDR) || (hdr_q == 16'd0)));
      tx.TX_EOF_N     = !((state_q == S_PAY) && last_word);
      tx.TX_REM       = last_word ? REM_W'(rem_mask) : '1;
    end
  end

  assign ERR         = err_q;
  assign FRAMES_SENT = frames_q;
endmodule

// File: tb/tb_fl_frame_gen.sv
// tb/tb_fl_frame_gen.sv - directed self-checking bench for fl_frame_gen (DATA_WIDTH=32)
module tb_fl_frame_gen;
  logic        CLK = 1'b0;
  logic        RESET, START, STOP;
  logic [15:0] FRAME_COUNT, HDR_LEN, PAY_LEN;
  logic [7:0]  SEED;
  logic        BUSY, ERR;
  logic [15:0] FRAMES_SENT;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;

  logic [31:0] cap_data[16];
  logic [3:0]  cap_flg[16];
  logic [1:0]  cap_rem[16];
  int          cap_cyc[16];

  fl_frame_gen_if #(.DATA_WIDTH(32)) tx ();

  fl_frame_gen #(.DATA_WIDTH(32)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .STOP(STOP),
    .FRAME_COUNT(FRAME_COUNT), .HDR_LEN(HDR_LEN), .PAY_LEN(PAY_LEN), .SEED(SEED),
    .tx(tx), .BUSY(BUSY), .ERR(ERR), .FRAMES_SENT(FRAMES_SENT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  // Flags are packed {SOF_N, EOF_N, SOP_N, EOP_N}
  task automatic collect(input int n, input bit rnd);
    int          got = 0;
    int          budget = 0;
    logic        stalled = 1'b0;
    logic [38:0] snap = '0;
    while (got < n && budget < 400) begin
      if (stalled)
        check("stall_hold", {tx.TX_SRC_RDY_N, tx.TX_DATA, tx.TX_SOF_N, tx.TX_EOF_N,
                             tx.TX_SOP_N, tx.TX_EOP_N, tx.TX_REM}, {1'b0, snap});
      tx.TX_DST_RDY_N = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      stalled = 1'b0;
      if (!tx.TX_SRC_RDY_N) begin
        if (!tx.TX_DST_RDY_N) begin
          cap_data[got] = tx.TX_DATA;
          cap_flg[got]  = {tx.TX_SOF_N, tx.TX_EOF_N, tx.TX_SOP_N, tx.TX_EOP_N};
          cap_rem[got]  = tx.TX_REM;
          cap_cyc[got]  = cyc;
          got++;
        end else begin
          snap    = {tx.TX_DATA, tx.TX_SOF_N, tx.TX_EOF_N, tx.TX_SOP_N, tx.TX_EOP_N, tx.TX_REM};
          stalled = 1'b1;
        end
      end
      @(negedge CLK);
      budget++;
    end
    tx.TX_DST_RDY_N = 1'b0;
    if (got < n) check("collect_timeout", 64'(got), 64'(n));
  endtask

  task automatic check_word(input string tag, input int i, input logic [31:0] d,
                            input logic [3:0] f, input logic [1:0] r);
    check({tag, "_data"}, 64'(cap_data[i]), 64'(d));
    check({tag, "_flags"}, 64'(cap_flg[i]), 64'(f));
    check({tag, "_rem"}, 64'(cap_rem[i]), 64'(r));
  endtask

  initial begin
    RESET = 1'b0; START = 1'b0; STOP = 1'b0;
    FRAME_COUNT = 16'd1; HDR_LEN = 16'd3; PAY_LEN = 16'd6; SEED = 8'h10;
    tx.TX_DST_RDY_N = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_outputs", {tx.TX_SRC_RDY_N, tx.TX_SOF_N, tx.TX_EOF_N, tx.TX_SOP_N, tx.TX_EOP_N,
                          BUSY, ERR}, 7'b1111100);
    check("rst_data", 64'(tx.TX_DATA), 64'h0);
    check("rst_rem", 64'(tx.TX_REM), 64'h0);
    check("rst_frames", 64'(FRAMES_SENT), 64'h0);
    RESET = 1'b1;
    @(negedge CLK);

    // Header 3 bytes + payload 6 bytes, sink always ready
    pulse_start();
    check("latency_src_rdy", 64'(tx.TX_SRC_RDY_N), 64'h0);
    collect(3, 1'b0);
    check_word("f1_w0", 0, 32'h00121110, 4'b0100, 2'd2);
    check_word("f1_w1", 1, 32'h13121110, 4'b1101, 2'd3);
    check_word("f1_w2", 2, 32'h00001514, 4'b1010, 2'd1);
    check("f1_busy", 64'(BUSY), 64'h0);
    check("f1_frames", 64'(FRAMES_SENT), 64'd1);
    check("f1_src_idle", 64'(tx.TX_SRC_RDY_N), 64'h1);

    // Same frame under random sink back-pressure
    pulse_start();
    collect(3, 1'b1);
    check_word("bp_w0", 0, 32'h00121110, 4'b0100, 2'd2);
    check_word("bp_w1", 1, 32'h13121110, 4'b1101, 2'd3);
    check_word("bp_w2", 2, 32'h00001514, 4'b1010, 2'd1);
    check("bp_frames", 64'(FRAMES_SENT), 64'd1);
    check("bp_busy", 64'(BUSY), 64'h0);

    // Three single-word frames back to back
    HDR_LEN = 16'd0; PAY_LEN = 16'd4; FRAME_COUNT = 16'd3; SEED = 8'hA0;
    pulse_start();
    collect(3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_word($sformatf("b2b_w%0d", i), i, 32'hA3A2A1A0, 4'b0000, 2'd3);
      if (i > 0) check($sformatf("b2b_gap%0d", i), 64'(cap_cyc[i] - cap_cyc[i-1]), 64'd1);
    end
    check("b2b_frames", 64'(FRAMES_SENT), 64'd3);
    check("b2b_busy", 64'(BUSY), 64'h0);

    // Continuous run stopped during payload of frame 5
    HDR_LEN = 16'd2; PAY_LEN = 16'd8; FRAME_COUNT = 16'd0; SEED = 8'h00;
    pulse_start();
    collect(13, 1'b0);
    STOP = 1'b1;
    collect(1, 1'b0);
    STOP = 1'b0;
    check_word("stop_w14", 0, 32'h03020100, 4'b1101, 2'd3);
    collect(1, 1'b0);
    check_word("stop_w15", 0, 32'h07060504, 4'b1010, 2'd3);
    check("stop_frames", 64'(FRAMES_SENT), 64'd5);
    check("stop_busy", 64'(BUSY), 64'h0);
    repeat (3) @(negedge CLK);
    check("stop_stays_idle", 64'(tx.TX_SRC_RDY_N), 64'h1);

    // STOP in the same cycle as the EOF transfer ends the run after that frame
    HDR_LEN = 16'd0; PAY_LEN = 16'd4; FRAME_COUNT = 16'd0; SEED = 8'h20;
    pulse_start();
    STOP = 1'b1;
    collect(1, 1'b0);
    STOP = 1'b0;
    check_word("stop_eof_w0", 0, 32'h23222120, 4'b0000, 2'd3);
    check("stop_eof_frames", 64'(FRAMES_SENT), 64'd1);
    check("stop_eof_busy", 64'(BUSY), 64'h0);

    // Zero-length payload is rejected
    PAY_LEN = 16'd0;
    pulse_start();
    check("err_pulse", {ERR, BUSY, tx.TX_SRC_RDY_N}, 3'b101);
    @(negedge CLK);
    check("err_cleared", {ERR, BUSY, tx.TX_SRC_RDY_N}, 3'b001);

    // Reset during a payload stall, then a clean restart
    HDR_LEN = 16'd0; PAY_LEN = 16'd8; FRAME_COUNT = 16'd1; SEED = 8'h40;
    pulse_start();
    collect(1, 1'b0);
    tx.TX_DST_RDY_N = 1'b1;
    @(negedge CLK);
    check("rst_stall_word", {tx.TX_SRC_RDY_N, tx.TX_DATA}, {1'b0, 32'h47464544});
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_mid_src", {tx.TX_SRC_RDY_N, BUSY}, 2'b10);
    check("rst_mid_frames", 64'(FRAMES_SENT), 64'h0);
    RESET = 1'b1;
    tx.TX_DST_RDY_N = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check($sformatf("rst_quiet%0d", i), {tx.TX_SRC_RDY_N, BUSY}, 2'b10);
    end
    pulse_start();
    tx.TX_DST_RDY_N = 1'b1;
    PAY_LEN = 16'd0;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    PAY_LEN = 16'd8;
    check("busy_start_ignored", {ERR, BUSY}, 2'b01);
    collect(2, 1'b0);
    check_word("restart_w0", 0, 32'h43424140, 4'b0101, 2'd3);
    check_word("restart_w1", 1, 32'h47464544, 4'b1010, 2'd3);
    check("restart_frames", 64'(FRAMES_SENT), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
